// File: rtl/regfile_write_arbiter_if.sv
// Write-back request/ack bundle plus register-file write strobe for regfile_write_arbiter.
// master = requester/register-file side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              req0_valid;
    logic [IDX_W-1:0]  req0_index;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ack;
    logic              req1_valid;
    logic [IDX_W-1:0]  req1_index;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ack;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_index;
    logic [DATA_W-1:0] rf_data;
    logic              busy;

    modport master (
        output req0_valid, req0_index, req0_data,
        output req1_valid, req1_index, req1_data,
        input  req0_ack, req1_ack, rf_we, rf_index, rf_data, busy
    );

    modport slave (
        input  req0_valid, req0_index, req0_data,
        input  req1_valid, req1_index, req1_data,
        output req0_ack, req1_ack, rf_we, rf_index, rf_data, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: arbitrates two write-back requesters onto one regfile write port; REGFILE_ARB_ROUND_ROBIN_EN selects round-robin ties (else req0 wins).
// Latency: valid sampled at edge n -> rf_we/ack high in cycle n+1; grants at most every 3 cycles.
// Backpressure: requester holds valid until ack; arbiter stays in RELEASE until the winner drops valid.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } wr_t;

    state_t state_q, state_d;
    logic   winner_q, winner_d;
    wr_t    wr_q, wr_d;
    logic   we_q, we_d;
    logic   ack0_q, ack0_d;
    logic   ack1_q, ack1_d;
    logic   busy_q, busy_d;
    logic   tie_pick;
    logic   pick;
    wr_t    req0_wr, req1_wr, sel_wr;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;
    assign tie_pick = ~rr_last_q;
`else
    assign tie_pick = 1'b0;
`endif

    assign req0_wr = {bus.req0_index, bus.req0_data};
    assign req1_wr = {bus.req1_index, bus.req1_data};

    always_comb begin
        pick = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            pick = tie_pick;
        end else if (bus.req1_valid) begin
            pick = 1'b1;
        end
    end

    assign sel_wr = pick ? req1_wr : req0_wr;

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        wr_d     = wr_q;
        we_d     = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    winner_d = pick;
                    wr_d     = sel_wr;
                    // $zero is never written, but the requester still gets its ack
                    we_d     = (sel_wr.index != '0);
                    ack0_d   = ~pick;
                    ack1_d   = pick;
                    state_d  = WRITE;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
                    if (bus.req0_valid && bus.req1_valid) begin
                        rr_last_d = pick;
                    end
`endif
                end
            end
            WRITE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!(winner_q ? bus.req1_valid : bus.req0_valid)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            wr_q     <= '0;
            we_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            wr_q     <= wr_d;
            we_q     <= we_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    assign bus.rf_we    = we_q;
    assign bus.rf_index = wr_q.index;
    assign bus.rf_data  = wr_q.data;
    assign bus.req0_ack = ack0_q;
    assign bus.req1_ack = ack1_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, contention sequences, random traffic vs a transaction-level model.
module tb_regfile_write_arbiter;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus();

    regfile_write_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] dut_rf [32];
    logic [31:0] m_rf   [32];

    always @(negedge clk) begin
        if (bus.rf_we) dut_rf[bus.rf_index] = bus.rf_data;
    end

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  i0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  i1;
        logic [31:0] d1;
        logic        we;
        logic [4:0]  idx;
        logic [31:0] dat;
        logic        a0;
        logic        a1;
        logic        bsy;
    } vec_t;

    vec_t tbl [28];

    // transaction-level model: who owns the port and how long since its grant
    int          m_owner;
    int          m_age;
    logic        m_we, m_a0, m_a1, m_busy;
    logic [4:0]  m_idx;
    logic [31:0] m_dat;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    int          m_rr;
`endif

    task automatic drive(input logic rst, input logic v0, input logic [4:0] i0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] i1, input logic [31:0] d1);
        reset          = rst;
        bus.req0_valid = v0;
        bus.req0_index = i0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_index = i1;
        bus.req1_data  = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic we, input logic [4:0] idx, input logic [31:0] dat,
                         input logic a0, input logic a1, input logic bsy);
        logic [40:0] act, exp;
        act = {bus.rf_we, bus.rf_index, bus.rf_data, bus.req0_ack, bus.req1_ack, bus.busy};
        exp = {we, idx, dat, a0, a1, bsy};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got we=%0b idx=%0d data=%h ack0=%0b ack1=%0b busy=%0b, want we=%0b idx=%0d data=%h ack0=%0b ack1=%0b busy=%0b",
                     name, cyc, bus.rf_we, bus.rf_index, bus.rf_data, bus.req0_ack, bus.req1_ack, bus.busy,
                     we, idx, dat, a0, a1, bsy);
        end
    endtask

    task automatic model_edge(input logic rst, input logic v0, input logic [4:0] i0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] i1, input logic [31:0] d1);
        int w;
        m_we = 1'b0;
        m_a0 = 1'b0;
        m_a1 = 1'b0;
        if (!rst) begin
            m_owner = -1;
            m_age   = 0;
            m_idx   = '0;
            m_dat   = '0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            m_rr    = 1;
`endif
        end else if (m_owner < 0) begin
            if (v0 || v1) begin
                if (v0 && v1) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
                    w    = (m_rr == 1) ? 0 : 1;
                    m_rr = w;
`else
                    w = 0;
`endif
                end else begin
                    w = v1 ? 1 : 0;
                end
                m_owner = w;
                m_age   = 1;
                m_idx   = (w == 1) ? i1 : i0;
                m_dat   = (w == 1) ? d1 : d0;
                m_we    = (m_idx != 5'd0);
                m_a0    = (w == 0);
                m_a1    = (w == 1);
                if (m_we) m_rf[m_idx] = m_dat;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (!((m_owner == 1) ? v1 : v0)) begin
            m_owner = -1;
        end
        m_busy = (m_owner >= 0);
    endtask

    initial begin
        int t1, t2, exp_w;
        logic        rv  [2];
        logic [4:0]  ri  [2];
        logic [31:0] rd  [2];
        int          hold[2];
        logic        rrst;

        tbl[0]  = '{0,1,5'd1,32'h1,1,5'd2,32'h2,            0,5'd0,32'h0,0,0,0};
        tbl[1]  = '{0,1,5'd1,32'h1,1,5'd2,32'h2,            0,5'd0,32'h0,0,0,0};
        tbl[2]  = '{1,1,5'd1,32'h1,1,5'd2,32'h2,            1,5'd1,32'h1,1,0,1};
        tbl[3]  = '{1,0,5'd1,32'h1,1,5'd2,32'h2,            0,5'd1,32'h1,0,0,1};
        tbl[4]  = '{1,0,5'd1,32'h1,1,5'd2,32'h2,            0,5'd1,32'h1,0,0,0};
        tbl[5]  = '{1,0,5'd1,32'h1,1,5'd2,32'h2,            1,5'd2,32'h2,0,1,1};
        tbl[6]  = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd2,32'h2,0,0,1};
        tbl[7]  = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd2,32'h2,0,0,0};
        tbl[8]  = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd2,32'h2,0,0,0};
        tbl[9]  = '{1,1,5'd5,32'hDEADBEEF,0,5'd0,32'h0,     1,5'd5,32'hDEADBEEF,1,0,1};
        tbl[10] = '{1,0,5'd5,32'hDEADBEEF,0,5'd0,32'h0,     0,5'd5,32'hDEADBEEF,0,0,1};
        tbl[11] = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd5,32'hDEADBEEF,0,0,0};
        tbl[12] = '{1,0,5'd0,32'h0,1,5'd0,32'hFFFFFFFF,     0,5'd0,32'hFFFFFFFF,0,1,1};
        tbl[13] = '{1,0,5'd0,32'h0,0,5'd0,32'hFFFFFFFF,     0,5'd0,32'hFFFFFFFF,0,0,1};
        tbl[14] = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd0,32'hFFFFFFFF,0,0,0};
        tbl[15] = '{1,1,5'd7,32'hA,0,5'd0,32'h0,            1,5'd7,32'hA,1,0,1};
        tbl[16] = '{1,0,5'd7,32'hA,1,5'd7,32'hB,            0,5'd7,32'hA,0,0,1};
        tbl[17] = '{1,0,5'd7,32'hA,1,5'd7,32'hB,            0,5'd7,32'hA,0,0,0};
        tbl[18] = '{1,0,5'd7,32'hA,1,5'd7,32'hB,            1,5'd7,32'hB,0,1,1};
        tbl[19] = '{1,0,5'd0,32'h0,0,5'd7,32'hB,            0,5'd7,32'hB,0,0,1};
        tbl[20] = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd7,32'hB,0,0,0};
        tbl[21] = '{1,1,5'd9,32'h99,0,5'd0,32'h0,           1,5'd9,32'h99,1,0,1};
        tbl[22] = '{1,1,5'd9,32'h99,0,5'd0,32'h0,           0,5'd9,32'h99,0,0,1};
        tbl[23] = '{1,1,5'd9,32'h99,0,5'd0,32'h0,           0,5'd9,32'h99,0,0,1};
        tbl[24] = '{0,1,5'd9,32'h99,0,5'd0,32'h0,           0,5'd0,32'h0,0,0,0};
        tbl[25] = '{1,1,5'd9,32'h99,0,5'd0,32'h0,           1,5'd9,32'h99,1,0,1};
        tbl[26] = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd9,32'h99,0,0,1};
        tbl[27] = '{1,0,5'd0,32'h0,0,5'd0,32'h0,            0,5'd9,32'h99,0,0,0};

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].i0, tbl[i].d0, tbl[i].v1, tbl[i].i1, tbl[i].d1);
            step();
            check($sformatf("table[%0d]", i), tbl[i].we, tbl[i].idx, tbl[i].dat, tbl[i].a0, tbl[i].a1, tbl[i].bsy);
        end

        // contention after reset: req0 first, req1 three cycles later
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        check("contend_reset", 0, 5'd0, 32'h0, 0, 0, 0);
        drive(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        step();
        t1 = cyc;
        check("contend_grant0", 1, 5'd3, 32'h11, 1, 0, 1);
        bus.req0_valid = 1'b0;
        step();
        check("contend_write_end", 0, 5'd3, 32'h11, 0, 0, 1);
        step();
        check("contend_release", 0, 5'd3, 32'h11, 0, 0, 0);
        step();
        t2 = cyc;
        check("contend_grant1", 1, 5'd4, 32'h22, 0, 1, 1);
        n_vec++;
        if (t2 - t1 != 3) begin
            n_err++;
            $display("FAIL grant_spacing: got %0d cycles, want 3", t2 - t1);
        end
        bus.req1_valid = 1'b0;
        step();
        check("contend_tail0", 0, 5'd4, 32'h22, 0, 0, 1);
        step();
        check("contend_tail1", 0, 5'd4, 32'h22, 0, 0, 0);

        // both requesters keep re-requesting; tie outcome depends on the build
        for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            exp_w = (k % 2 == 0) ? 1 : 0;
`else
            exp_w = 0;
`endif
            drive(1, 1, 5'(k + 8), 32'h100 + k, 1, 5'(k + 16), 32'h200 + k);
            step();
            if (exp_w == 0) check($sformatf("rerequest_grant[%0d]", k), 1, 5'(k + 8), 32'h100 + k, 1, 0, 1);
            else            check($sformatf("rerequest_grant[%0d]", k), 1, 5'(k + 16), 32'h200 + k, 0, 1, 1);
            if (exp_w == 0) bus.req0_valid = 1'b0;
            else            bus.req1_valid = 1'b0;
            step();
            step();
            check($sformatf("rerequest_idle[%0d]", k), 0, bus.rf_index, bus.rf_data, 0, 0, 0);
        end

        // random traffic against the model
        for (int r = 0; r < 32; r++) begin
            dut_rf[r] = '0;
            m_rf[r]   = '0;
        end
        for (int r = 0; r < 2; r++) begin
            rv[r] = 1'b0; ri[r] = '0; rd[r] = '0; hold[r] = 0;
        end
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        model_edge(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        check("rand_reset", m_we, m_idx, m_dat, m_a0, m_a1, m_busy);

        for (int c = 0; c < 1500; c++) begin
            rrst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            drive(rrst, rv[0], ri[0], rd[0], rv[1], ri[1], rd[1]);
            model_edge(rrst, rv[0], ri[0], rd[0], rv[1], ri[1], rd[1]);
            step();
            check("rand", m_we, m_idx, m_dat, m_a0, m_a1, m_busy);
            for (int r = 0; r < 2; r++) begin
                if ((r == 0) ? m_a0 : m_a1) hold[r] = $urandom_range(1, 3);
                if (hold[r] > 0) begin
                    hold[r]--;
                    if (hold[r] == 0) rv[r] = 1'b0;
                end else if (!rv[r] && $urandom_range(0, 2) == 0) begin
                    rv[r] = 1'b1;
                    ri[r] = ($urandom_range(0, 3) == 0) ? 5'd7 : 5'($urandom_range(0, 31));
                    rd[r] = $urandom;
                end
            end
        end
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        step();
        step();
        step();

        for (int r = 0; r < 32; r++) begin
            n_vec++;
            if (dut_rf[r] !== m_rf[r]) begin
                n_err++;
                $display("FAIL regfile[%0d]: got %h, want %h", r, dut_rf[r], m_rf[r]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
